ring_heater_lock_ctrl: RTL and testbench

- Closed-loop thermal lock controller for a resonant ring modulator.
- Drives the heater DAC code consumed by the thermal tuner stage.
- Reads a photodetector ADC sample of the ring thru-port power, where resonance equals minimum power.
- Performs a coarse heater sweep to find resonance, then dither-tracks it. Re-sweeps on loss of lock.

---
 rtl/ring_heater_lock_ctrl_if.sv | 25 ++
 rtl/ring_heater_lock_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_ring_heater_lock_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_heater_lock_ctrl_if.sv
// Bundle of the controller's run/sample/heater signals.
//   master : controlling host + photodetector side (drives enable, pd_valid, pd_data)
//   slave  : lock controller (drives heater_code, heater_update, locked, state)
interface ring_heater_lock_ctrl_if #(
  parameter int DAC_W = 12,
  parameter int ADC_W = 10
);
  logic             enable;
  logic             pd_valid;
  logic [ADC_W-1:0] pd_data;
  logic [DAC_W-1:0] heater_code;
  logic             heater_update;
  logic             locked;
  logic [1:0]       state;

  modport master (
    output enable, pd_valid, pd_data,
    input  heater_code, heater_update, locked, state
  );

  modport slave (
    input  enable, pd_valid, pd_data,
    output heater_code, heater_update, locked, state
  );
endinterface

// File: rtl/ring_heater_lock_ctrl.sv
// Closed-loop thermal lock controller for a resonant ring modulator.
// Coarse-sweeps the heater DAC code looking for minimum thru-port power,
// then dither-tracks the minimum (center / +dither / -dither) and re-sweeps
// when the center power drifts out of margin too many times in a row.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ring_heater_lock_ctrl_if
//              in : enable, pd_valid, pd_data
//              out: heater_code, heater_update, locked, state (0 idle,1 sweep,2 track)
module ring_heater_lock_ctrl #(
  parameter int DAC_W         = 12,
  parameter int ADC_W         = 10,
  parameter int STEP          = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DITHER        = 4,
  parameter int LOCK_MARGIN   = 32,
  parameter int LOSS_COUNT    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ring_heater_lock_ctrl_if.slave   bus
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int LOSS_W = $clog2(LOSS_COUNT + 1);
  localparam logic [DAC_W-1:0] CODE_MAX = {DAC_W{1'b1}};
  localparam logic [ADC_W-1:0] PWR_MAX  = {ADC_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_TRACK = 2'd2} state_t;
  typedef enum logic [1:0] {PH_CENTER = 2'd0, PH_PLUS = 2'd1, PH_MINUS = 2'd2} phase_t;

  state_t            state_reg;
  phase_t            phase_reg;
  logic [DAC_W-1:0]  code_reg;
  logic              update_reg;
  logic              locked_reg;
  logic [ADC_W-1:0]  best_pwr_reg;
  logic [DAC_W-1:0]  best_code_reg;
  logic [DAC_W-1:0]  center_reg;
  logic [ADC_W-1:0]  ref_reg;
  logic [ADC_W-1:0]  hi_reg;
  logic [LOSS_W-1:0] loss_cnt_reg;
  logic [SET_W-1:0]  settle_reg;

  // Datapath helpers
  logic              accept;
  logic [DAC_W:0]    sweep_sum;
  logic              sweep_done;
  logic              is_better;
  logic [DAC_W-1:0]  sweep_best_code;
  logic [DAC_W:0]    plus_sum;
  logic [DAC_W-1:0]  plus_code;
  logic [DAC_W-1:0]  minus_code;
  logic              in_margin;
  logic              go_up;
  logic              go_down;
  logic [DAC_W-1:0]  center_next;
  logic [LOSS_W-1:0] loss_next;
  logic              loss_hit;

  always_comb begin
    // A sample is only taken once the heater has settled on the current code.
    accept          = bus.enable && (state_reg != S_IDLE) && bus.pd_valid && (settle_reg == '0);
    sweep_sum       = {1'b0, code_reg} + (DAC_W+1)'(STEP);
    sweep_done      = sweep_sum > {1'b0, CODE_MAX};
    is_better       = bus.pd_data < best_pwr_reg;          // strict: ties keep the lower code
    sweep_best_code = is_better ? code_reg : best_code_reg;

    plus_sum  = {1'b0, center_reg} + (DAC_W+1)'(DITHER);
    plus_code = (plus_sum > {1'b0, CODE_MAX}) ? CODE_MAX : plus_sum[DAC_W-1:0];
    minus_code = ({1'b0, center_reg} >= (DAC_W+1)'(DITHER))
               ? center_reg - DAC_W'(DITHER) : '0;

    // One extra bit so best_pwr + margin cannot wrap.
    in_margin = {1'b0, bus.pd_data} <= ({1'b0, best_pwr_reg} + (ADC_W+1)'(LOCK_MARGIN));

    // In the MINUS phase the current sample is lo.
    go_up       = (hi_reg < ref_reg) && (hi_reg <= bus.pd_data);
    go_down     = bus.pd_data < ref_reg;
    center_next = center_reg;
    if (go_up) begin
      if (center_reg != CODE_MAX) center_next = center_reg + 1'b1;
    end else if (go_down) begin
      if (center_reg != '0) center_next = center_reg - 1'b1;
    end

    loss_next = loss_cnt_reg + 1'b1;
    loss_hit  = loss_next == LOSS_W'(LOSS_COUNT);
  end

  // Every code load reloads the settle counter; heater_update pulses only
  // when the value actually differs from the current code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      phase_reg     <= PH_CENTER;
      code_reg      <= '0;
      update_reg    <= 1'b0;
      locked_reg    <= 1'b0;
      best_pwr_reg  <= PWR_MAX;
      best_code_reg <= '0;
      center_reg    <= '0;
      ref_reg       <= '0;
      hi_reg        <= '0;
      loss_cnt_reg  <= '0;
      settle_reg    <= '0;
    end else begin
      update_reg <= 1'b0;
      if (settle_reg != '0) settle_reg <= settle_reg - 1'b1;

      if (!bus.enable) begin
        state_reg    <= S_IDLE;
        phase_reg    <= PH_CENTER;
        locked_reg   <= 1'b0;
        loss_cnt_reg <= '0;
        code_reg     <= '0;
        update_reg   <= code_reg != '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg     <= S_SWEEP;
            phase_reg     <= PH_CENTER;
            best_pwr_reg  <= PWR_MAX;
            best_code_reg <= '0;
            loss_cnt_reg  <= '0;
            code_reg      <= '0;
            update_reg    <= code_reg != '0;
            settle_reg    <= SET_W'(SETTLE_CYCLES);
          end

          S_SWEEP: begin
            if (accept) begin
              if (is_better) begin
                best_pwr_reg  <= bus.pd_data;
                best_code_reg <= code_reg;
              end
              if (sweep_done) begin
                state_reg  <= S_TRACK;
                phase_reg  <= PH_CENTER;
                center_reg <= sweep_best_code;
                code_reg   <= sweep_best_code;
                update_reg <= sweep_best_code != code_reg;
              end else begin
                code_reg   <= sweep_sum[DAC_W-1:0];
                update_reg <= 1'b1;
              end
              settle_reg <= SET_W'(SETTLE_CYCLES);
            end
          end

          S_TRACK: begin
            if (accept) begin
              settle_reg <= SET_W'(SETTLE_CYCLES);
              case (phase_reg)
                PH_CENTER: begin
                  ref_reg <= bus.pd_data;
                  if (in_margin || !loss_hit) begin
                    if (in_margin) begin
                      loss_cnt_reg <= '0;
                      locked_reg   <= 1'b1;
                    end else begin
                      loss_cnt_reg <= loss_next;  // locked holds while below the limit
                    end
                    phase_reg  <= PH_PLUS;
                    code_reg   <= plus_code;
                    update_reg <= plus_code != code_reg;
                  end else begin
                    // Lost lock: restart the coarse sweep from code 0.
                    locked_reg    <= 1'b0;
                    loss_cnt_reg  <= '0;
                    state_reg     <= S_SWEEP;
                    phase_reg     <= PH_CENTER;
                    best_pwr_reg  <= PWR_MAX;
                    best_code_reg <= '0;
                    code_reg      <= '0;
                    update_reg    <= code_reg != '0;
                  end
                end
                PH_PLUS: begin
                  hi_reg     <= bus.pd_data;
                  phase_reg  <= PH_MINUS;
                  code_reg   <= minus_code;
                  update_reg <= minus_code != code_reg;
                end
                PH_MINUS: begin
                  center_reg <= center_next;
                  phase_reg  <= PH_CENTER;
                  code_reg   <= center_next;
                  update_reg <= center_next != code_reg;
                end
                default: phase_reg <= PH_CENTER;
              endcase
            end
          end

          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.heater_code   = code_reg;
  assign bus.heater_update = update_reg;
  assign bus.locked        = locked_reg;
  assign bus.state         = state_reg;

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Bench for ring_heater_lock_ctrl: a short table of cycle vectors for reset/idle
// behaviour, then scoreboarded runs where a transaction-level model of the
// sweep/track algorithm queues the expected code on every heater_update pulse.
module tb_ring_heater_lock_ctrl;
  localparam int DAC_W = 6, ADC_W = 8, STEP = 8, SETTLE = 4, DITHER = 2;
  localparam int MARGIN = 10, LOSS = 3, CMAX = 63;

  logic clk, rst;
  ring_heater_lock_ctrl_if #(.DAC_W(DAC_W), .ADC_W(ADC_W)) bus ();

  ring_heater_lock_ctrl #(
    .DAC_W(DAC_W), .ADC_W(ADC_W), .STEP(STEP), .SETTLE_CYCLES(SETTLE),
    .DITHER(DITHER), .LOCK_MARGIN(MARGIN), .LOSS_COUNT(LOSS)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  // Photodetector plant
  bit         use_plant = 0;
  int         plant_min = 26;
  bit         plant_flat = 0;
  logic [7:0] tbl_pdd = '0;

  function automatic int pd_of(input int code, input int mn, input bit flat);
    int d, v;
    if (flat) return 100;
    d = (code > mn) ? code - mn : mn - code;
    v = 200 - 4 * (20 - d);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  always_comb bus.pd_data = use_plant ? 8'(pd_of(int'(bus.heater_code), plant_min, plant_flat)) : tbl_pdd;

  // Transaction-level algorithm model
  typedef struct { int code; int st; bit lk; } exp_t;
  exp_t expq[$];
  int m_state, m_code, m_best_pwr, m_best_code, m_center, m_phase;
  int m_ref, m_hi, m_loss, m_min;
  bit m_locked, m_flat;

  task automatic model_start();
    m_state = 1; m_code = 0; m_best_pwr = 255; m_best_code = 0;
    m_phase = 0; m_loss = 0; m_locked = 0;
  endtask

  task automatic model_step();
    int s, nc, plus, minus;
    s = pd_of(m_code, m_min, m_flat);
    nc = m_code;
    plus  = (m_center + DITHER > CMAX) ? CMAX : m_center + DITHER;
    minus = (m_center - DITHER < 0) ? 0 : m_center - DITHER;
    if (m_state == 1) begin
      if (s < m_best_pwr) begin m_best_pwr = s; m_best_code = m_code; end
      if (m_code + STEP > CMAX) begin
        m_state = 2; m_center = m_best_code; m_phase = 0; nc = m_center;
      end else nc = m_code + STEP;
    end else begin
      case (m_phase)
        0: begin
          m_ref = s;
          if (s <= m_best_pwr + MARGIN) begin
            m_loss = 0; m_locked = 1; m_phase = 1; nc = plus;
          end else begin
            m_loss++;
            if (m_loss == LOSS) begin
              m_locked = 0; m_loss = 0; m_state = 1; m_best_pwr = 255;
              m_best_code = 0; m_phase = 0; nc = 0;
            end else begin
              m_phase = 1; nc = plus;
            end
          end
        end
        1: begin m_hi = s; m_phase = 2; nc = minus; end
        default: begin
          if (m_hi < m_ref && m_hi <= s) m_center = (m_center == CMAX) ? CMAX : m_center + 1;
          else if (s < m_ref) m_center = (m_center == 0) ? 0 : m_center - 1;
          m_phase = 0; nc = m_center;
        end
      endcase
    end
    if (nc != m_code) expq.push_back('{code: nc, st: m_state, lk: m_locked});
    m_code = nc;
  endtask

  task automatic predict(input int n);
    for (int i = 0; i < n; i++) model_step();
  endtask

  // Pulse monitor: one line per transaction, pops the scoreboard
  bit mon_en = 0;
  int last_pulse = -1;
  always @(posedge clk) begin
    #1;
    if (mon_en && bus.heater_update) begin
      if (expq.size() == 0) begin
        chk("unexpected_pulse", int'(bus.heater_code), -1);
      end else begin
        exp_t e;
        e = expq.pop_front();
        $display("pulse cyc=%0d code=%0d state=%0d locked=%0d exp_code=%0d",
                 cyc, bus.heater_code, bus.state, bus.locked, e.code);
        chk("pulse_code", int'(bus.heater_code), e.code);
        chk("pulse_state", int'(bus.state), e.st);
        chk("pulse_locked", int'(bus.locked), int'(e.lk));
      end
      if (last_pulse >= 0) chk("settle_gap_ok", int'((cyc - last_pulse) >= SETTLE + 1), 1);
      last_pulse = cyc;
    end
  end

  task automatic run_until_empty(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (expq.size() == 0) break;
    end
    if (expq.size() != 0) begin
      chk("scoreboard_timeout_left", expq.size(), 0);
      expq.delete();
    end
    mon_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; bus.enable = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic start_run(input int steps);
    model_start();
    predict(steps);
    @(negedge clk);
    bus.enable = 1; mon_en = 1; last_pulse = -1;
  endtask

  task automatic chk_model_outputs(input string tag);
    chk({tag, "_state"}, int'(bus.state), m_state);
    chk({tag, "_code"}, int'(bus.heater_code), m_code);
    chk({tag, "_locked"}, int'(bus.locked), int'(m_locked));
  endtask

  typedef struct {
    logic rst, en, pdv;
    logic [7:0] pdd;
    int st, code, upd, lk;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1; bus.enable = 0; bus.pd_valid = 0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 0, 0, 0, 0};  // reset
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'd5, 0, 0, 0, 0};  // pd_valid ignored in idle
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd5, 1, 0, 0, 0};  // enable -> sweep at 0, no pulse
    vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd5, 1, 0, 0, 0};  // settling, sample ignored
    vecs[4] = '{1'b0, 1'b0, 1'b1, 8'd5, 0, 0, 0, 0};  // disable -> idle, code already 0
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd5, 1, 0, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 8'd5, 0, 0, 0, 0};  // rst overrides enable
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; bus.enable = vecs[i].en; bus.pd_valid = vecs[i].pdv; tbl_pdd = vecs[i].pdd;
      @(posedge clk); #1;
      $display("vec %0d state=%0d code=%0d upd=%0d locked=%0d", i, bus.state, bus.heater_code,
               bus.heater_update, bus.locked);
      chk($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].st);
      chk($sformatf("vec%0d_code", i), int'(bus.heater_code), vecs[i].code);
      chk($sformatf("vec%0d_upd", i), int'(bus.heater_update), vecs[i].upd);
      chk($sformatf("vec%0d_locked", i), int'(bus.locked), vecs[i].lk);
    end

    // Sweep, lock, track with minimum at 26
    use_plant = 1; bus.pd_valid = 1;
    plant_min = 26; plant_flat = 0; m_min = 26; m_flat = 0;
    do_reset();
    start_run(23);
    run_until_empty(23 * 6 + 20);
    chk_model_outputs("track26");
    chk("track26_locked_const", int'(bus.locked), 1);

    // Resonance moves to 40 while tracking: loss of lock and re-acquire
    plant_min = 40; m_min = 40;
    mon_en = 1;
    predict(30);
    run_until_empty(30 * 6 + 20);
    chk_model_outputs("relock40");
    chk("relock40_code_const", int'(bus.heater_code), 40);

    // Flat response: ties keep code 0, minus dither saturates without a pulse
    plant_flat = 1; m_flat = 1;
    do_reset();
    start_run(15);
    run_until_empty(15 * 6 + 20);
    chk_model_outputs("flat");
    chk("flat_code_const", int'(bus.heater_code), 2);

    // Drop enable mid-sweep at code 32
    plant_flat = 0; m_flat = 0; plant_min = 26; m_min = 26;
    do_reset();
    @(negedge clk); bus.enable = 1;
    begin
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(posedge clk); #1;
        if (bus.heater_update && bus.heater_code == 6'd32) seen = 1;
      end
      chk("reach_code32", int'(seen), 1);
    end
    @(negedge clk); bus.enable = 0;
    @(posedge clk); #1;
    chk("abort_state", int'(bus.state), 0);
    chk("abort_code", int'(bus.heater_code), 0);
    chk("abort_upd", int'(bus.heater_update), 1);
    chk("abort_locked", int'(bus.locked), 0);
    start_run(23);
    @(posedge clk); #1;
    chk("restart_state", int'(bus.state), 1);
    chk("restart_code", int'(bus.heater_code), 0);
    run_until_empty(23 * 6 + 20);
    chk_model_outputs("restart_track");

    // Reset while tracking with samples arriving
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("rst_state", int'(bus.state), 0);
    chk("rst_code", int'(bus.heater_code), 0);
    chk("rst_upd", int'(bus.heater_update), 0);
    chk("rst_locked", int'(bus.locked), 0);
    model_start();
    predict(23);
    @(negedge clk); rst = 0; mon_en = 1; last_pulse = -1;
    run_until_empty(23 * 6 + 20);
    chk_model_outputs("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
